// File: rtl/control_unit.sv
// control_unit: multicycle FETCH -> DECODE -> EXECUTE sequencer (plus HALT) for a 16-bit accumulator CPU.
// Conditional branches BEQ..BLE exist only when CONTROL_UNIT_BRANCH_EN is defined; JMP and the Z/N status register always exist.
module control_unit #(
  parameter int ADDR_WIDTH   = 11,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                               clock_in,
  input  logic                               reset_in,
  input  logic [OPCODE_WIDTH+ADDR_WIDTH-1:0] instruction_in,
  input  logic                               zero_indicator_in,
  input  logic                               signal_bit_in,
  output logic [ADDR_WIDTH-1:0]              pc_out,
  output logic [ADDR_WIDTH-1:0]              operand_out,
  output logic                               operation_out,
  output logic                               src_sel_out,
  output logic [1:0]                         acc_sel_out,
  output logic                               acc_wr_out,
  output logic                               mem_wr_out,
  output logic                               halted_out,
  output logic [1:0]                         state_out,
  output logic [1:0]                         status_out
);

  localparam int INSTR_WIDTH = OPCODE_WIDTH + ADDR_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
`ifdef CONTROL_UNIT_BRANCH_EN
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(13);
`endif
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(14);

  localparam logic [1:0] ACC_SEL_ALU = 2'b00;
  localparam logic [1:0] ACC_SEL_MEM = 2'b01;
  localparam logic [1:0] ACC_SEL_IMM = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [INSTR_WIDTH-1:0]    ir;
  logic [ADDR_WIDTH-1:0]     pc;
  logic                      flag_z;
  logic                      flag_n;
  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [ADDR_WIDTH-1:0]     operand;
  logic                      is_alu_op;
  logic                      branch_taken;
  logic [ADDR_WIDTH-1:0]     pc_next;

  assign opcode      = ir[INSTR_WIDTH-1:ADDR_WIDTH];
  assign operand     = ir[ADDR_WIDTH-1:0];
  assign is_alu_op   = (opcode == OP_ADD) || (opcode == OP_ADDI) ||
                       (opcode == OP_SUB) || (opcode == OP_SUBI);
  assign pc_out      = pc;
  assign operand_out = operand;
  assign state_out   = state;
  assign status_out  = {flag_z, flag_n};

  // State register
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:   state_next = ST_DECODE;
      ST_DECODE:  state_next = ST_EXECUTE;
      ST_EXECUTE: state_next = (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
      ST_HALT:    state_next = ST_HALT;
      default:    state_next = ST_FETCH;
    endcase
  end

  // Output logic: every strobe and select is qualified by EXECUTE, so reset clears them at once
  always_comb begin
    acc_wr_out    = 1'b0;
    mem_wr_out    = 1'b0;
    operation_out = 1'b0;
    src_sel_out   = 1'b0;
    acc_sel_out   = ACC_SEL_ALU;
    halted_out    = (state == ST_HALT);
    if (state == ST_EXECUTE) begin
      case (opcode)
        OP_STO: mem_wr_out = 1'b1;
        OP_LD: begin
          acc_wr_out  = 1'b1;
          acc_sel_out = ACC_SEL_MEM;
        end
        OP_LDI: begin
          acc_wr_out  = 1'b1;
          acc_sel_out = ACC_SEL_IMM;
        end
        OP_ADD, OP_SUB: begin
          acc_wr_out    = 1'b1;
          operation_out = (opcode == OP_SUB);
        end
        OP_ADDI, OP_SUBI: begin
          acc_wr_out    = 1'b1;
          src_sel_out   = 1'b1;
          operation_out = (opcode == OP_SUBI);
        end
        default: ;
      endcase
    end
  end

  // Branch decision on the latched status; disabled conditional opcodes fall to NOP
  always_comb begin
    branch_taken = 1'b0;
    case (opcode)
      OP_JMP: branch_taken = 1'b1;
`ifdef CONTROL_UNIT_BRANCH_EN
      OP_BEQ: branch_taken = flag_z;
      OP_BNE: branch_taken = !flag_z;
      OP_BGT: branch_taken = !flag_n && !flag_z;
      OP_BGE: branch_taken = !flag_n;
      OP_BLT: branch_taken = flag_n;
      OP_BLE: branch_taken = flag_n || flag_z;
`endif
      default: branch_taken = 1'b0;
    endcase
  end

  assign pc_next = branch_taken ? operand : pc + ADDR_WIDTH'(1);

  // Datapath registers: IR at end of DECODE, PC and flags at end of EXECUTE
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      ir     <= '0;
      pc     <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      if (state == ST_DECODE) begin
        ir <= instruction_in;
      end
      if (state == ST_EXECUTE && opcode != OP_HLT) begin
        pc <= pc_next;
      end
      if (state == ST_EXECUTE && is_alu_op) begin
        flag_z <= zero_indicator_in;
        flag_n <= signal_bit_in;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, hand-written reset/halt sequences,
// and a randomized instruction stream checked against an instruction-level reference model.
module tb_control_unit;

  localparam int AW     = 11;
  localparam int OW     = 5;
  localparam int IW     = AW + OW;
  localparam int N_RAND = 400;
  localparam int N_VEC  = 14;
`ifdef CONTROL_UNIT_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic          clock_in = 1'b0;
  logic          reset_in = 1'b0;
  logic [IW-1:0] instruction_in;
  logic          zero_indicator_in;
  logic          signal_bit_in;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] operand_out;
  logic          operation_out;
  logic          src_sel_out;
  logic [1:0]    acc_sel_out;
  logic          acc_wr_out;
  logic          mem_wr_out;
  logic          halted_out;
  logic [1:0]    state_out;
  logic [1:0]    status_out;

  int            checks   = 0;
  int            failures = 0;
  logic [AW-1:0] cur_pc;

  // Control word order: {acc_wr, mem_wr, operation, src_sel, acc_sel[1:0]}
  typedef struct packed {
    logic [IW-1:0] instr;
    logic          zin;
    logic          nin;
    logic [5:0]    ctrl;
    logic [AW-1:0] next_pc;
    logic [1:0]    zn;
  } vec_t;

  vec_t tbl [N_VEC];

  logic [IW+1:0] stim_q[$];
  logic [18:0]   exp_q[$];

  control_unit #(.ADDR_WIDTH(AW), .OPCODE_WIDTH(OW)) dut (
    .clock_in          (clock_in),
    .reset_in          (reset_in),
    .instruction_in    (instruction_in),
    .zero_indicator_in (zero_indicator_in),
    .signal_bit_in     (signal_bit_in),
    .pc_out            (pc_out),
    .operand_out       (operand_out),
    .operation_out     (operation_out),
    .src_sel_out       (src_sel_out),
    .acc_sel_out       (acc_sel_out),
    .acc_wr_out        (acc_wr_out),
    .mem_wr_out        (mem_wr_out),
    .halted_out        (halted_out),
    .state_out         (state_out),
    .status_out        (status_out)
  );

  // Clock / watchdog
  always #5 clock_in = ~clock_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failures=%0d", failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctrl_now();
    return {acc_wr_out, mem_wr_out, operation_out, src_sel_out, acc_sel_out};
  endfunction

  // Reference model: control word for one instruction in its EXECUTE cycle
  function automatic logic [5:0] model_ctrl(input logic [IW-1:0] instr);
    int         opc;
    logic       wr_acc, wr_mem, sub, imm;
    logic [1:0] sel;
    opc    = int'(instr[IW-1:AW]);
    wr_acc = 1'b0; wr_mem = 1'b0; sub = 1'b0; imm = 1'b0; sel = 2'b00;
    if (opc == 1) begin
      wr_mem = 1'b1;
    end else if (opc == 2) begin
      wr_acc = 1'b1; sel = 2'b01;
    end else if (opc == 3) begin
      wr_acc = 1'b1; sel = 2'b10;
    end else if (opc >= 4 && opc <= 7) begin
      wr_acc = 1'b1;
      imm    = (opc % 2 == 1);
      sub    = (opc >= 6);
    end
    return {wr_acc, wr_mem, sub, imm, sel};
  endfunction

  // Reference model: program counter after one instruction
  function automatic logic [AW-1:0] model_next_pc(input logic [IW-1:0] instr, input int pc,
                                                  input bit z, input bit n);
    int opc;
    bit taken;
    opc   = int'(instr[IW-1:AW]);
    taken = 1'b0;
    if (opc == 14) taken = 1'b1;
    else if (BR_EN && opc >= 8 && opc <= 13) begin
      case (opc)
        8:       taken = z;
        9:       taken = !z;
        10:      taken = !n && !z;
        11:      taken = !n;
        12:      taken = n;
        13:      taken = n || z;
        default: taken = 1'b0;
      endcase
    end
    if (opc == 0) return AW'(pc);
    return taken ? instr[AW-1:0] : AW'((pc + 1) % 2048);
  endfunction

  // Driver: one full instruction starting in FETCH (called at posedge+1)
  task automatic do_instr(input logic [IW-1:0] instr, input logic zin, input logic nin,
                          input logic [5:0] exp_ctrl, input logic [AW-1:0] exp_pc,
                          input logic [1:0] exp_zn);
    check("fetch_state", state_out, 0);
    check("fetch_pc", pc_out, cur_pc);
    check("fetch_ctrl", ctrl_now(), 0);
    instruction_in    = IW'($urandom);
    zero_indicator_in = 1'($urandom);
    signal_bit_in     = 1'($urandom);
    @(posedge clock_in); #1;
    check("decode_state", state_out, 1);
    check("decode_pc", pc_out, cur_pc);
    check("decode_ctrl", ctrl_now(), 0);
    instruction_in = instr;
    @(posedge clock_in); #1;
    instruction_in    = IW'($urandom);
    zero_indicator_in = zin;
    signal_bit_in     = nin;
    check("exec_state", state_out, 2);
    check("exec_operand", operand_out, instr[AW-1:0]);
    check("exec_ctrl", ctrl_now(), exp_ctrl);
    check("exec_pc", pc_out, cur_pc);
    check("exec_halted", halted_out, 0);
    @(posedge clock_in); #1;
    zero_indicator_in = 1'($urandom);
    signal_bit_in     = 1'($urandom);
    check("post_status", status_out, exp_zn);
    check("post_pc", pc_out, exp_pc);
    check("post_ctrl", ctrl_now(), 0);
    if (instr[IW-1:AW] == '0) begin
      for (int k = 0; k < 4; k++) begin
        check("halt_state", state_out, 3);
        check("halt_flag", halted_out, 1);
        check("halt_ctrl", ctrl_now(), 0);
        check("halt_pc", pc_out, exp_pc);
        @(posedge clock_in); #1;
      end
    end else begin
      check("post_state", state_out, 0);
      check("post_halted", halted_out, 0);
    end
    cur_pc = exp_pc;
  endtask

  task automatic apply_reset();
    reset_in = 1'b1;
    #1;
    check("rst_pc", pc_out, 0);
    check("rst_state", state_out, 0);
    check("rst_ctrl", ctrl_now(), 0);
    check("rst_halted", halted_out, 0);
    check("rst_status", status_out, 0);
    check("rst_operand", operand_out, 0);
    repeat (2) @(posedge clock_in);
    #1;
    check("rst_hold_pc", pc_out, 0);
    check("rst_hold_state", state_out, 0);
    reset_in = 1'b0;
    cur_pc   = '0;
  endtask

  initial begin
    logic [IW-1:0] ins;
    logic          zi, ni;
    logic [5:0]    c;
    logic [AW-1:0] npc;
    logic [IW+1:0] s;
    logic [18:0]   e;
    int            m_pc;
    bit            m_z, m_n;
    int            opc;

    instruction_in    = '0;
    zero_indicator_in = 1'b0;
    signal_bit_in     = 1'b0;
    #1;

    // Directed program from reset: {instr, zin, nin, ctrl, next_pc, status after}
    tbl[0]  = '{{5'd3,  11'h005}, 1'b0, 1'b0, 6'b100010, 11'h001, 2'b00};                       // LDI 5
    tbl[1]  = '{{5'd7,  11'h003}, 1'b1, 1'b0, 6'b101100, 11'h002, 2'b10};                       // SUBI 3, zero
    tbl[2]  = '{{5'd8,  11'h040}, 1'b0, 1'b1, 6'b000000, BR_EN ? 11'h040 : 11'h003, 2'b10};     // BEQ
    tbl[3]  = '{{5'd4,  11'h010}, 1'b0, 1'b1, 6'b100000, BR_EN ? 11'h041 : 11'h004, 2'b01};     // ADD, negative
    tbl[4]  = '{{5'd10, 11'h010}, 1'b1, 1'b1, 6'b000000, BR_EN ? 11'h042 : 11'h005, 2'b01};     // BGT not taken
    tbl[5]  = '{{5'd12, 11'h010}, 1'b0, 1'b0, 6'b000000, BR_EN ? 11'h010 : 11'h006, 2'b01};     // BLT
    tbl[6]  = '{{5'd1,  11'h123}, 1'b1, 1'b0, 6'b010000, BR_EN ? 11'h011 : 11'h007, 2'b01};     // STO 0x123
    tbl[7]  = '{{5'd14, 11'h7FF}, 1'b0, 1'b0, 6'b000000, 11'h7FF, 2'b01};                       // JMP 0x7FF
    tbl[8]  = '{{5'd4,  11'h000}, 1'b1, 1'b1, 6'b100000, 11'h000, 2'b11};                       // ADD at 0x7FF wraps
    tbl[9]  = '{{5'd2,  11'h055}, 1'b0, 1'b0, 6'b100001, 11'h001, 2'b11};                       // LD keeps flags
    tbl[10] = '{{5'd6,  11'h001}, 1'b0, 1'b0, 6'b101000, 11'h002, 2'b00};                       // SUB
    tbl[11] = '{{5'd9,  11'h100}, 1'b1, 1'b1, 6'b000000, BR_EN ? 11'h100 : 11'h003, 2'b00};     // BNE
    tbl[12] = '{{5'd15, 11'h2AA}, 1'b1, 1'b1, 6'b000000, BR_EN ? 11'h101 : 11'h004, 2'b00};     // undefined -> NOP
    tbl[13] = '{{5'd5,  11'h7FF}, 1'b0, 1'b1, 6'b100100, BR_EN ? 11'h102 : 11'h005, 2'b01};     // ADDI

    apply_reset();
    for (int i = 0; i < N_VEC; i++) begin
      do_instr(tbl[i].instr, tbl[i].zin, tbl[i].nin, tbl[i].ctrl, tbl[i].next_pc, tbl[i].zn);
    end
    do_instr({5'd0, 11'h000}, 1'b1, 1'b1, 6'b000000, tbl[N_VEC-1].next_pc, tbl[N_VEC-1].zn);

    // LDI 5; HLT from reset: PC stays at 1 while halted
    apply_reset();
    do_instr({5'd3, 11'h005}, 1'b0, 1'b0, 6'b100010, 11'h001, 2'b00);
    do_instr({5'd0, 11'h3C3}, 1'b0, 1'b0, 6'b000000, 11'h001, 2'b00);

    // Reset asserted in the middle of a STO EXECUTE cycle
    apply_reset();
    do_instr({5'd3, 11'h005}, 1'b0, 1'b0, 6'b100010, 11'h001, 2'b00);
    do_instr({5'd4, 11'h020}, 1'b1, 1'b1, 6'b100000, 11'h002, 2'b11);
    check("mid_fetch_pc", pc_out, 2);
    @(posedge clock_in); #1;
    instruction_in = {5'd1, 11'h123};
    @(posedge clock_in); #1;
    check("mid_exec_memwr", mem_wr_out, 1);
    check("mid_exec_accwr", acc_wr_out, 0);
    check("mid_exec_operand", operand_out, 11'h123);
    zero_indicator_in = 1'b0;
    signal_bit_in     = 1'b0;
    #2 reset_in = 1'b1;
    #1;
    check("mid_rst_memwr", mem_wr_out, 0);
    check("mid_rst_pc", pc_out, 0);
    check("mid_rst_state", state_out, 0);
    check("mid_rst_status", status_out, 0);
    @(posedge clock_in); #1;
    reset_in = 1'b0;
    cur_pc   = '0;
    do_instr({5'd1, 11'h0AB}, 1'b1, 1'b0, 6'b010000, 11'h001, 2'b00);

    // Randomized stream: model builds the expected queue, driver replays and compares
    apply_reset();
    m_pc = 0; m_z = 1'b0; m_n = 1'b0;
    for (int i = 0; i < N_RAND; i++) begin
      ins[IW-1:AW] = OW'($urandom_range(1, 31));
      ins[AW-1:0]  = AW'($urandom_range(0, 2047));
      zi  = 1'($urandom);
      ni  = 1'($urandom);
      c   = model_ctrl(ins);
      npc = model_next_pc(ins, m_pc, m_z, m_n);
      opc = int'(ins[IW-1:AW]);
      if (opc >= 4 && opc <= 7) begin
        m_z = zi;
        m_n = ni;
      end
      m_pc = int'(npc);
      stim_q.push_back({ins, zi, ni});
      exp_q.push_back({c, npc, m_z, m_n});
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      do_instr(s[IW+1:2], s[1], s[0], e[18:13], e[12:2], e[1:0]);
    end
    do_instr({5'd0, 11'h000}, 1'b0, 1'b0, 6'b000000, AW'(m_pc), {m_z, m_n});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
